atm_keypad_frontend: RTL and testbench

ATM_KEYPAD_FRONTEND -- requirements
Module: atm_keypad_frontend

---
 rtl/atm_keypad_frontend.sv | 201 ++++++++++++++++++++
 tb/tb_atm_keypad_frontend.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/atm_keypad_frontend.sv
// ATM keypad front end: collects account, PIN, operation, amount and new PIN
// from single-cycle key strobes and presents them as one request to the ATM controller.
//
// state    | meaning
// S_ACC    | waiting for account digit + ENTER
// S_PIN    | collecting 4-digit BCD PIN
// S_OP     | selecting operation 1-5
// S_AMT    | entering binary transaction amount
// S_NEWPIN | collecting 4-digit replacement PIN
// S_SEND   | request valid, waiting for req_ready
module atm_keypad_frontend #(
  parameter logic [15:0] MAX_AMT = 16'd9999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        req_ready,
  output logic        req_valid,
  output logic [2:0]  operation,
  output logic [3:0]  acc_num,
  output logic [15:0] pin,
  output logic [15:0] new_pin,
  output logic [15:0] amount,
  output logic        key_err,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_ACC    = 3'd0,
    S_PIN    = 3'd1,
    S_OP     = 3'd2,
    S_AMT    = 3'd3,
    S_NEWPIN = 3'd4,
    S_SEND   = 3'd5
  } state_t;

  localparam logic [3:0] K_ENTER  = 4'hA;
  localparam logic [3:0] K_CLEAR  = 4'hB;
  localparam logic [3:0] K_CANCEL = 4'hC;

  state_t      state_q, state_n;
  logic        acc_cnt, acc_cnt_n;
  logic [2:0]  pin_cnt, pin_cnt_n;
  logic [2:0]  np_cnt, np_cnt_n;
  logic [3:0]  acc_n;
  logic [15:0] pin_n, np_n, amt_n;
  logic [2:0]  op_n;
  logic        err_n;
  logic        clear_all;
  logic        is_digit;
  logic [20:0] amt_calc;
  logic        amt_ok;

  assign state    = state_q;
  assign is_digit = (key_code <= 4'd9);
  // Widened so the x10 step can never wrap before the limit compare.
  assign amt_calc = 21'(amount) * 21'd10 + 21'(key_code);
  assign amt_ok   = (amt_calc <= 21'(MAX_AMT));

  always_comb begin
    state_n   = state_q;
    acc_n     = acc_num;
    acc_cnt_n = acc_cnt;
    pin_n     = pin;
    pin_cnt_n = pin_cnt;
    np_n      = new_pin;
    np_cnt_n  = np_cnt;
    op_n      = operation;
    amt_n     = amount;
    err_n     = 1'b0;
    clear_all = 1'b0;

    case (state_q)
      S_SEND: begin
        if (req_ready) begin
          if (operation == 3'd5) begin
            clear_all = 1'b1;
            state_n   = S_ACC;
          end else begin
            if (operation == 3'd4) pin_n = new_pin;
            op_n     = 3'd0;
            amt_n    = 16'd0;
            np_n     = 16'd0;
            np_cnt_n = 3'd0;
            state_n  = S_OP;
          end
        end
      end
      S_ACC, S_PIN, S_OP, S_AMT, S_NEWPIN: begin
        if (key_valid) begin
          if (key_code == K_CANCEL) begin
            clear_all = 1'b1;
            state_n   = S_ACC;
          end else if (key_code == K_CLEAR) begin
            case (state_q)
              S_ACC:    begin acc_n = 4'd0;   acc_cnt_n = 1'b0; end
              S_PIN:    begin pin_n = 16'd0;  pin_cnt_n = 3'd0; end
              S_OP:     op_n = 3'd0;
              S_AMT:    amt_n = 16'd0;
              S_NEWPIN: begin np_n = 16'd0;   np_cnt_n = 3'd0; end
              default:  ;
            endcase
          end else if (key_code > K_CANCEL) begin
            err_n = 1'b1;
          end else begin
            case (state_q)
              S_ACC: begin
                if (is_digit) begin
                  acc_n     = key_code;
                  acc_cnt_n = 1'b1;
                end else if (acc_cnt) state_n = S_PIN;
                else err_n = 1'b1;
              end
              S_PIN: begin
                if (is_digit) begin
                  if (pin_cnt < 3'd4) begin
                    pin_n     = {pin[11:0], key_code};
                    pin_cnt_n = pin_cnt + 3'd1;
                  end else err_n = 1'b1;
                end else if (pin_cnt == 3'd4) state_n = S_OP;
                else err_n = 1'b1;
              end
              S_OP: begin
                if (is_digit) begin
                  if (key_code >= 4'd1 && key_code <= 4'd5) op_n = key_code[2:0];
                  else err_n = 1'b1;
                end else begin
                  case (operation)
                    3'd2, 3'd3: state_n = S_AMT;
                    3'd4:       state_n = S_NEWPIN;
                    3'd1, 3'd5: state_n = S_SEND;
                    default:    err_n = 1'b1;
                  endcase
                end
              end
              S_AMT: begin
                if (is_digit) begin
                  if (amt_ok) amt_n = amt_calc[15:0];
                  else err_n = 1'b1;
                end else if (amount != 16'd0) state_n = S_SEND;
                else err_n = 1'b1;
              end
              S_NEWPIN: begin
                if (is_digit) begin
                  if (np_cnt < 3'd4) begin
                    np_n     = {new_pin[11:0], key_code};
                    np_cnt_n = np_cnt + 3'd1;
                  end else err_n = 1'b1;
                end else if (np_cnt == 3'd4) state_n = S_SEND;
                else err_n = 1'b1;
              end
              default: ;
            endcase
          end
        end
      end
      default: state_n = S_ACC;
    endcase

    if (clear_all) begin
      acc_n     = 4'd0;
      acc_cnt_n = 1'b0;
      pin_n     = 16'd0;
      pin_cnt_n = 3'd0;
      np_n      = 16'd0;
      np_cnt_n  = 3'd0;
      op_n      = 3'd0;
      amt_n     = 16'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_ACC;
      req_valid <= 1'b0;
      key_err   <= 1'b0;
      operation <= 3'd0;
      acc_num   <= 4'd0;
      acc_cnt   <= 1'b0;
      pin       <= 16'd0;
      pin_cnt   <= 3'd0;
      new_pin   <= 16'd0;
      np_cnt    <= 3'd0;
      amount    <= 16'd0;
    end else begin
      state_q   <= state_n;
      req_valid <= (state_n == S_SEND);
      key_err   <= err_n;
      operation <= op_n;
      acc_num   <= acc_n;
      acc_cnt   <= acc_cnt_n;
      pin       <= pin_n;
      pin_cnt   <= pin_cnt_n;
      new_pin   <= np_n;
      np_cnt    <= np_cnt_n;
      amount    <= amt_n;
    end
  end

endmodule

// File: tb/tb_atm_keypad_frontend.sv
// Directed bench for atm_keypad_frontend: scenario tasks with hand-computed expectations.
module tb_atm_keypad_frontend;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'd0;
  logic        req_ready = 1'b0;
  logic        req_valid;
  logic [2:0]  operation;
  logic [3:0]  acc_num;
  logic [15:0] pin, new_pin, amount;
  logic        key_err;
  logic [2:0]  state;

  int total = 0;
  int bad = 0;

  atm_keypad_frontend #(.MAX_AMT(16'd9999)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .req_ready(req_ready), .req_valid(req_valid), .operation(operation),
    .acc_num(acc_num), .pin(pin), .new_pin(new_pin), .amount(amount),
    .key_err(key_err), .state(state)
  );

  always #5 clk = ~clk;

  // One key strobe; returns on the falling edge right after the edge that consumed it.
  task automatic press(input logic [3:0] c);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = c;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic transfer();
    @(negedge clk);
    req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    total++; if (state !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state); end
    total++; if (req_valid !== 1'b0) begin bad++; $display("FAIL reset_req_valid got=%0b exp=0", req_valid); end
    total++; if (key_err !== 1'b0) begin bad++; $display("FAIL reset_key_err got=%0b exp=0", key_err); end
    total++; if ({acc_num, operation, pin, new_pin, amount} !== 55'd0) begin bad++;
      $display("FAIL reset_fields acc=%0d op=%0d pin=%h np=%h amt=%0d exp all 0", acc_num, operation, pin, new_pin, amount); end
  endtask

  task automatic test_withdraw();
    press(4'hA);
    total++; if (key_err !== 1'b1 || state !== 3'd0) begin bad++; $display("FAIL acc_enter_empty err=%0b state=%0d exp err=1 state=0", key_err, state); end
    press(4'd3); press(4'hA);
    total++; if (state !== 3'd1 || acc_num !== 4'd3) begin bad++; $display("FAIL acc_to_pin state=%0d acc=%0d exp 1/3", state, acc_num); end
    press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'hA);
    total++; if (state !== 3'd2 || pin !== 16'h1234) begin bad++; $display("FAIL pin_to_op state=%0d pin=%h exp 2/1234", state, pin); end
    press(4'hE);
    total++; if (key_err !== 1'b1 || state !== 3'd2 || operation !== 3'd0) begin bad++; $display("FAIL invalid_code err=%0b state=%0d op=%0d exp 1/2/0", key_err, state, operation); end
    press(4'd2); press(4'hA); press(4'd5); press(4'd0); press(4'hA);
    total++; if (req_valid !== 1'b1 || state !== 3'd5) begin bad++; $display("FAIL wd_send rv=%0b state=%0d exp 1/5", req_valid, state); end
    total++; if (acc_num !== 4'd3 || pin !== 16'h1234 || operation !== 3'd2 || amount !== 16'd50) begin bad++;
      $display("FAIL wd_fields acc=%0d pin=%h op=%0d amt=%0d exp 3/1234/2/50", acc_num, pin, operation, amount); end
    transfer();
    total++; if (state !== 3'd2 || req_valid !== 1'b0 || operation !== 3'd0 || amount !== 16'd0) begin bad++;
      $display("FAIL wd_after state=%0d rv=%0b op=%0d amt=%0d exp 2/0/0/0", state, req_valid, operation, amount); end
    total++; if (acc_num !== 4'd3 || pin !== 16'h1234) begin bad++; $display("FAIL wd_keep acc=%0d pin=%h exp 3/1234", acc_num, pin); end
  endtask

  task automatic test_amount_limit();
    press(4'd3); press(4'hA);
    total++; if (state !== 3'd3) begin bad++; $display("FAIL amt_enter state=%0d exp 3", state); end
    press(4'hA);
    total++; if (key_err !== 1'b1 || state !== 3'd3) begin bad++; $display("FAIL amt_zero_enter err=%0b state=%0d exp 1/3", key_err, state); end
    for (int i = 0; i < 4; i++) begin
      press(4'd9);
      total++; if (key_err !== 1'b0) begin bad++; $display("FAIL amt_digit_err i=%0d got=%0b exp 0", i, key_err); end
    end
    total++; if (amount !== 16'd9999) begin bad++; $display("FAIL amt_9999 got=%0d exp 9999", amount); end
    press(4'd9);
    total++; if (key_err !== 1'b1 || amount !== 16'd9999) begin bad++; $display("FAIL amt_over err=%0b amt=%0d exp 1/9999", key_err, amount); end
    @(negedge clk);
    total++; if (key_err !== 1'b0) begin bad++; $display("FAIL amt_err_pulse got=%0b exp 0", key_err); end
    press(4'hA);
    total++; if (state !== 3'd5 || operation !== 3'd3 || amount !== 16'd9999) begin bad++;
      $display("FAIL amt_send state=%0d op=%0d amt=%0d exp 5/3/9999", state, operation, amount); end
    transfer();
  endtask

  task automatic test_pin_entry();
    press(4'hC);
    total++; if (state !== 3'd0 || acc_num !== 4'd0 || pin !== 16'd0) begin bad++; $display("FAIL cancel_op state=%0d acc=%0d pin=%h exp 0/0/0", state, acc_num, pin); end
    press(4'd7); press(4'hA); press(4'd1); press(4'd2);
    total++; if (pin !== 16'h0012) begin bad++; $display("FAIL pin_partial got=%h exp 0012", pin); end
    press(4'hA);
    total++; if (key_err !== 1'b1 || state !== 3'd1 || pin !== 16'h0012) begin bad++; $display("FAIL pin_short_enter err=%0b state=%0d pin=%h exp 1/1/0012", key_err, state, pin); end
    press(4'hB);
    total++; if (pin !== 16'd0 || state !== 3'd1 || key_err !== 1'b0 || acc_num !== 4'd7) begin bad++;
      $display("FAIL pin_clear pin=%h state=%0d err=%0b acc=%0d exp 0/1/0/7", pin, state, key_err, acc_num); end
    press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'd5);
    total++; if (key_err !== 1'b1 || pin !== 16'h1234) begin bad++; $display("FAIL pin_fifth err=%0b pin=%h exp 1/1234", key_err, pin); end
    press(4'hC);
    total++; if (state !== 3'd0 || {acc_num, operation, pin, new_pin, amount} !== 55'd0) begin bad++;
      $display("FAIL pin_cancel state=%0d acc=%0d pin=%h exp all 0", state, acc_num, pin); end
  endtask

  task automatic test_change_pin();
    press(4'd3); press(4'hA); press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'hA);
    press(4'd0);
    total++; if (key_err !== 1'b1 || operation !== 3'd0) begin bad++; $display("FAIL op_zero err=%0b op=%0d exp 1/0", key_err, operation); end
    press(4'd6);
    total++; if (key_err !== 1'b1 || operation !== 3'd0) begin bad++; $display("FAIL op_six err=%0b op=%0d exp 1/0", key_err, operation); end
    press(4'd4); press(4'hA);
    total++; if (state !== 3'd4) begin bad++; $display("FAIL np_enter state=%0d exp 4", state); end
    press(4'hA);
    total++; if (key_err !== 1'b1 || state !== 3'd4) begin bad++; $display("FAIL np_short err=%0b state=%0d exp 1/4", key_err, state); end
    press(4'd5); press(4'd6); press(4'd7); press(4'd8); press(4'hA);
    total++; if (state !== 3'd5 || new_pin !== 16'h5678 || req_valid !== 1'b1) begin bad++;
      $display("FAIL np_send state=%0d np=%h rv=%0b exp 5/5678/1", state, new_pin, req_valid); end
    key_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      key_code = (i == 0) ? 4'hC : ((i == 1) ? 4'hD : 4'd1);
      @(negedge clk);
      total++; if (req_valid !== 1'b1 || state !== 3'd5 || key_err !== 1'b0 || new_pin !== 16'h5678 || pin !== 16'h1234 || operation !== 3'd4) begin bad++;
        $display("FAIL send_hold i=%0d rv=%0b state=%0d err=%0b np=%h pin=%h op=%0d", i, req_valid, state, key_err, new_pin, pin, operation); end
    end
    key_valid = 1'b0;
    transfer();
    total++; if (pin !== 16'h5678 || state !== 3'd2 || new_pin !== 16'd0 || req_valid !== 1'b0 || acc_num !== 4'd3) begin bad++;
      $display("FAIL np_transfer pin=%h state=%0d np=%h rv=%0b acc=%0d exp 5678/2/0/0/3", pin, state, new_pin, req_valid, acc_num); end
  endtask

  task automatic test_exit();
    press(4'd5); press(4'hA);
    total++; if (state !== 3'd5 || operation !== 3'd5) begin bad++; $display("FAIL exit_send state=%0d op=%0d exp 5/5", state, operation); end
    transfer();
    total++; if (state !== 3'd0 || req_valid !== 1'b0 || {acc_num, operation, pin, new_pin, amount} !== 55'd0) begin bad++;
      $display("FAIL exit_clear state=%0d rv=%0b acc=%0d pin=%h op=%0d exp all 0", state, req_valid, acc_num, pin, operation); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] seq [9] = '{4'd2, 4'hA, 4'd1, 4'd2, 4'd3, 4'd4, 4'hA, 4'd1, 4'hA};
    @(negedge clk);
    key_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      key_code = seq[i];
      @(negedge clk);
    end
    key_valid = 1'b0;
    total++; if (state !== 3'd5 || acc_num !== 4'd2 || pin !== 16'h1234 || operation !== 3'd1 || req_valid !== 1'b1) begin bad++;
      $display("FAIL b2b state=%0d acc=%0d pin=%h op=%0d rv=%0b exp 5/2/1234/1/1", state, acc_num, pin, operation, req_valid); end
  endtask

  task automatic test_reset_in_send();
    @(negedge clk);
    rst = 1'b0;
    req_ready = 1'b1;
    key_valid = 1'b1;
    key_code = 4'd7;
    @(negedge clk);
    rst = 1'b1;
    req_ready = 1'b0;
    key_valid = 1'b0;
    total++; if (req_valid !== 1'b0 || state !== 3'd0 || {acc_num, operation, pin, new_pin, amount} !== 55'd0) begin bad++;
      $display("FAIL send_reset rv=%0b state=%0d acc=%0d pin=%h exp all 0", req_valid, state, acc_num, pin); end
  endtask

  initial begin
    test_reset();
    test_withdraw();
    test_amount_limit();
    test_pin_entry();
    test_change_pin();
    test_exit();
    test_back_to_back();
    test_reset_in_send();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
